// File: rtl/sentinel_pkg.sv
// Shared types and constants for the sentinel authorization controller.
package sentinel_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_VERIFIED = 2'd1,
        ST_LOCKOUT  = 2'd2
    } state_t;

    // Status codes presented on status_out.
    localparam logic [7:0] STATUS_IDLE     = 8'h00;
    localparam logic [7:0] STATUS_VERIFIED = 8'hC1;
    localparam logic [7:0] STATUS_LOCKOUT  = 8'hE7;

    // Authorization key used when the instance does not override it.
    localparam logic [7:0] DEFAULT_AUTH_KEY = 8'hB6;

    // Maps a state to the status code it reports.
    function automatic logic [7:0] status_code(input state_t s);
        case (s)
            ST_VERIFIED: return STATUS_VERIFIED;
            ST_LOCKOUT:  return STATUS_LOCKOUT;
            default:     return STATUS_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/sentinel_lock_timer.sv
// Lockout down-counter: loadable, enable-gated, 8-bit, stops at zero.
module sentinel_lock_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [7:0] count;

    // Count register: load has priority over decrement; never wraps below zero.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            count <= 8'd0;
        end else if (ena) begin
            if (load) begin
                count <= load_val;
            end else if (dec && (count != 8'd0)) begin
                count <= count - 8'd1;
            end
        end
    end

    assign zero = (count == 8'd0);

endmodule

// File: rtl/sentinel_auth_ctrl.sv
// Authorization controller: key check, consecutive-failure counting and timed lockout.
module sentinel_auth_ctrl
    import sentinel_pkg::*;
#(
    parameter logic [7:0]  AUTH_KEY    = DEFAULT_AUTH_KEY,
    parameter int unsigned MAX_FAIL    = 3,
    parameter int unsigned LOCK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       key_valid,
    input  logic [7:0] key_in,
    input  logic       clear,
    output logic [7:0] status_out,
    output logic       verified,
    output logic       locked,
    output logic [3:0] fail_cnt
);

    localparam logic [3:0] MAX_FAIL_CNT = 4'(MAX_FAIL);
    localparam logic [4:0] MAX_FAIL_CMP = 5'(MAX_FAIL);
    localparam logic [7:0] LOCK_LOAD    = 8'(LOCK_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] fail_nxt;
    logic [4:0] fail_inc;
    logic       tmr_load;
    logic       tmr_dec;
    logic       tmr_zero;

    // Widened so the lockout threshold compare cannot overflow at 15.
    assign fail_inc = {1'b0, fail_cnt} + 5'd1;

    sentinel_lock_timer u_lock_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .load     (tmr_load),
        .load_val (LOCK_LOAD),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // State register; everything freezes while ena is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else if (ena) begin
            state <= state_nxt;
        end
    end

    // Next-state, failure-count and timer-control decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt = state;
        fail_nxt  = fail_cnt;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (key_valid) begin
                    if (key_in == AUTH_KEY) begin
                        state_nxt = ST_VERIFIED;
                        fail_nxt  = 4'd0;
                    end else if (fail_inc >= MAX_FAIL_CMP) begin
                        state_nxt = ST_LOCKOUT;
                        fail_nxt  = MAX_FAIL_CNT;
                        tmr_load  = 1'b1;
                    end else begin
                        fail_nxt  = fail_inc[3:0];
                    end
                end
            end
            ST_VERIFIED: begin
                // Strobes are ignored here; only clear leaves.
                if (clear) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                // Strobes and clear are ignored until the timer expires.
                if (tmr_zero) begin
                    state_nxt = ST_IDLE;
                    fail_nxt  = 4'd0;
                end else begin
                    tmr_dec   = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                fail_nxt  = 4'd0;
            end
        endcase
    end

    // Registered outputs, decoded from the upcoming state so they align with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fail_cnt   <= 4'd0;
            status_out <= STATUS_IDLE;
            verified   <= 1'b0;
            locked     <= 1'b0;
        end else if (ena) begin
            fail_cnt   <= fail_nxt;
            status_out <= status_code(state_nxt);
            verified   <= (state_nxt == ST_VERIFIED);
            locked     <= (state_nxt == ST_LOCKOUT);
        end
    end

endmodule

// File: tb/tb_sentinel_auth_ctrl.sv
// Scoreboard bench for sentinel_auth_ctrl: stimulus pushes expected outputs, a monitor compares.
module tb_sentinel_auth_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       key_valid = 1'b0;
    logic [7:0] key_in = 8'h00;
    logic       clear = 1'b0;
    logic [7:0] status_out;
    logic       verified;
    logic       locked;
    logic [3:0] fail_cnt;

    typedef struct packed {
        logic [7:0] status;
        logic       verified;
        logic       locked;
        logic [3:0] fail_cnt;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    passed = 0;

    sentinel_auth_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .key_valid  (key_valid),
        .key_in     (key_in),
        .clear      (clear),
        .status_out (status_out),
        .verified   (verified),
        .locked     (locked),
        .fail_cnt   (fail_cnt)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs on the falling edge and queue the outputs expected after the next rising edge.
    task automatic step(input logic r, input logic e, input logic kv, input logic [7:0] k,
                        input logic clr, input logic [7:0] st, input logic v, input logic l,
                        input logic [3:0] fc, input string nm);
        @(negedge clk);
        rst_n     = r;
        ena       = e;
        key_valid = kv;
        key_in    = k;
        clear     = clr;
        exp_q.push_back({st, v, l, fc});
        name_q.push_back(nm);
    endtask

    // Monitor: one registered output set per rising edge, compared against the queue head.
    initial begin
        obs_t  exp_v;
        obs_t  act_v;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                nm    = name_q.pop_front();
                act_v = {status_out, verified, locked, fail_cnt};
                checks++;
                if (act_v === exp_v) begin
                    passed++;
                end else begin
                    $display("FAIL %s @%0t: got status=%h verified=%b locked=%b fail_cnt=%0d, expected status=%h verified=%b locked=%b fail_cnt=%0d",
                             nm, $time, act_v.status, act_v.verified, act_v.locked, act_v.fail_cnt,
                             exp_v.status, exp_v.verified, exp_v.locked, exp_v.fail_cnt);
                end
            end
        end
    end

    initial begin
        int drain;

        // Reset held 5 cycles with a correct key presented and ena toggling.
        for (int i = 0; i < 5; i++)
            step(1'b0, i[0], 1'b1, 8'hB6, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0, "reset_hold");

        // First strobe after release is accepted.
        step(1'b1, 1'b1, 1'b1, 8'hB6, 1'b0, 8'hC1, 1'b1, 1'b0, 4'd0, "first_key_ok");
        step(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'hC1, 1'b1, 1'b0, 4'd0, "verified_ignores_key");
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'hC1, 1'b1, 1'b0, 4'd0, "ena_low_blocks_clear");
        step(1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0, "clear_beats_key");
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0, "clear_in_idle");
        step(1'b1, 1'b0, 1'b1, 8'hB6, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, "ena_low_key_ignored");

        // A correct key wipes a partial failure count.
        step(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 4'd1, "partial_fail");
        step(1'b1, 1'b1, 1'b1, 8'hB6, 1'b0, 8'hC1, 1'b1, 1'b0, 4'd0, "correct_clears_fail");
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0, "clear_to_idle");

        // Three wrong keys: count 1, 2, then a 16-cycle lockout that ignores key and clear.
        step(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 4'd1, "fail_1");
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 4'd1, "fail_hold");
        step(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 4'd2, "fail_2");
        step(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'hE7, 1'b0, 1'b1, 4'd3, "lock_enter");
        for (int i = 1; i < 16; i++)
            step(1'b1, 1'b1, (i == 3), 8'hB6, (i == 5), 8'hE7, 1'b0, 1'b1, 4'd3, "lockout_16");
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, "lock_exit_16");
        step(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 4'd1, "fail_after_lock");

        // Lockout with ena low for 4 cycles: locked stays high for 20 cycles in total.
        step(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 4'd2, "fail_2b");
        step(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'hE7, 1'b0, 1'b1, 4'd3, "lock_enter_b");
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'hE7, 1'b0, 1'b1, 4'd3, "lockout_pre_freeze");
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, 1'b1, 8'hB6, 1'b1, 8'hE7, 1'b0, 1'b1, 4'd3, "lockout_frozen");
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'hE7, 1'b0, 1'b1, 4'd3, "lockout_post_freeze");
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, "lock_exit_20");

        // Reset mid-lockout aborts it; the next strobe is counted from zero.
        step(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 4'd1, "fail_1c");
        step(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 4'd2, "fail_2c");
        step(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'hE7, 1'b0, 1'b1, 4'd3, "lock_enter_c");
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'hE7, 1'b0, 1'b1, 4'd3, "lockout_c");
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, "reset_mid_lock");
        step(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 4'd1, "post_reset_fail");
        step(1'b1, 1'b1, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0, 4'd2, "post_reset_fail_2");
        step(1'b1, 1'b1, 1'b1, 8'hB6, 1'b0, 8'hC1, 1'b1, 1'b0, 4'd0, "post_reset_key_ok");

        // Reset mid-verified returns to idle and stays there.
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, "reset_mid_verified");
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, "idle_after_reset");
        step(1'b1, 1'b1, 1'b1, 8'hB7, 1'b0, 8'h00, 1'b0, 1'b0, 4'd1, "near_miss_key");

        // Let the monitor drain the queue, bounded.
        drain = 0;
        while (exp_q.size() > 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain_timeout: %0d entries left, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sentinel_auth_ctrl.md
SENTINEL_AUTH_CTRL -- requirements
Module: sentinel_auth_ctrl

Interface
REQ-001 Parameter AUTH_KEY, 8'hB6, authorization key compared against key_in.
REQ-002 Parameter MAX_FAIL, 3, consecutive failed attempts that trigger lockout; legal range 1..15.
REQ-003 Parameter LOCK_CYCLES, 16, lockout duration in enabled clock cycles; legal range 1..255.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 ena  input  1  global enable; low freezes all state.
REQ-007 key_valid  input  1  single-cycle attempt strobe; key_in sampled when high.
REQ-008 key_in  input  8  presented key byte.
REQ-009 clear  input  1  leave VERIFIED, return to IDLE.
REQ-010 status_out  output  8  registered status code.
REQ-011 verified  output  1  high while state is VERIFIED.
REQ-012 locked  output  1  high while state is LOCKOUT.
REQ-013 fail_cnt  output  4  current consecutive-failure count.

Function
REQ-014 FSM states SHALL be IDLE, VERIFIED and LOCKOUT; all outputs SHALL be registered.
REQ-015 status_out SHALL be 8'h00 in IDLE, 8'hC1 in VERIFIED and 8'hE7 in LOCKOUT.
REQ-016 IDLE, key_valid with key_in==AUTH_KEY: next state VERIFIED; fail_cnt cleared; status_out 8'hC1 on the cycle after the strobe (latency 1).
REQ-017 IDLE, key_valid with key_in!=AUTH_KEY and fail_cnt+1<MAX_FAIL: stay IDLE; fail_cnt increments.
REQ-018 IDLE, key_valid with a wrong key and fail_cnt+1==MAX_FAIL: next state LOCKOUT; fail_cnt becomes MAX_FAIL; timer loads LOCK_CYCLES-1.
REQ-019 LOCKOUT: key_valid and clear ignored; timer decrements once per enabled cycle; when the timer is 0, next state IDLE and fail_cnt cleared.
REQ-020 LOCKOUT SHALL last exactly LOCK_CYCLES enabled cycles (locked high for LOCK_CYCLES cycles).
REQ-021 VERIFIED: clear high moves to IDLE next cycle; key_valid is ignored; clear has priority when it coincides with key_valid.
REQ-022 clear in IDLE or LOCKOUT SHALL have no effect.
REQ-023 status_out SHALL never equal 8'hC1 unless the previous enabled cycle was either a correct-key strobe in IDLE, or VERIFIED with clear low.
REQ-024 ena low: state, timer and fail_cnt hold; key_valid and clear ignored; outputs hold.
REQ-025 fail_cnt SHALL saturate at MAX_FAIL and never wrap.
REQ-026 Timer width SHALL be 8 bits; decrement SHALL never underflow.

Reset
REQ-027 rst_n low at a clock edge SHALL force IDLE, fail_cnt=0, timer=0, status_out=8'h00, verified=0 and locked=0, regardless of ena.
REQ-028 Reset asserted mid-LOCKOUT or mid-VERIFIED SHALL abort the operation with no residual state.
REQ-029 The first key_valid SHALL be accepted on the first enabled cycle after rst_n goes high.

Structure
REQ-030 Package sentinel_pkg SHALL hold the state enum, the status codes 8'h00/8'hC1/8'hE7 and the default AUTH_KEY.
REQ-031 Lockout timing SHALL be one sub-module, sentinel_lock_timer: load, enable, 8-bit down-count and a zero flag.
REQ-032 The FSM and fail counter SHALL live in sentinel_auth_ctrl.

Verification
REQ-033 Reset held 5 cycles, released, then key_valid with 8'hB6 -> next cycle status_out=8'hC1, verified=1, fail_cnt=0.
REQ-034 Three strobes of 8'h00 from IDLE -> fail_cnt 1, 2, then LOCKOUT; status_out=8'hE7 for exactly 16 cycles, then 8'h00 with fail_cnt=0.
REQ-035 Strobe 8'hB6 during LOCKOUT -> ignored; status_out remains 8'hE7 and the timer is unaffected.
REQ-036 In VERIFIED, clear and key_valid with 8'h11 in the same cycle -> IDLE next cycle, fail_cnt=0.
REQ-037 ena low for 4 cycles mid-LOCKOUT -> timer frozen; total locked-high duration is 20 cycles.
REQ-038 rst_n pulsed low mid-LOCKOUT -> next cycle IDLE, status_out=8'h00, fail_cnt=0.
